// File: rtl/cfglut_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// cfglut_reconfig_ctrl
//
// Purpose:
//   Sequences runtime reprogramming of one CFGLUT5 used as a 2-input
//   function y = f(I0=a, I1=b) with I2..I4 tied low.
//   - Accepts a 32-bit INIT word over a valid/ready handshake.
//   - Shifts the word serially into the LUT through CE/CDI, MSB first.
//   - After every reset it reloads RESET_INIT, so the LUT always returns to
//     a known function.
//   - cfg_valid tells downstream logic when the LUT output can be used.
//
// Ports:
//   clock      in   1   single clock, posedge
//   reset      in   1   asynchronous, active-low reset
//   req_valid  in   1   new INIT word offered
//   req_init   in   32  INIT word; bit k = LUT output for address k
//   req_ready  out  1   request can be accepted (IDLE only)
//   cfg_ce     out  1   CFGLUT5 CE; high exactly on shift cycles
//   cfg_cdi    out  1   CFGLUT5 CDI; current serial bit
//   cfg_valid  out  1   LUT contents equal cur_init
//   cur_init   out  32  word the LUT holds, or is being loaded with
//   busy       out  1   high in BOOT / SHIFT / DONE
//   done       out  1   one-cycle pulse when a load completes
// ---------------------------------------------------------------------------
module cfglut_reconfig_ctrl #(
   parameter logic [31:0] RESET_INIT = 32'hEEEE_EEEE,
   parameter bit          SKIP_SAME  = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_init,
   output logic        req_ready,
   output logic        cfg_ce,
   output logic        cfg_cdi,
   output logic        cfg_valid,
   output logic [31:0] cur_init,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2,
      ST_IDLE  = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [31:0] shreg_r;
   logic [31:0] shreg_s;
   logic [31:0] cur_r;
   logic [31:0] cur_s;
   logic [4:0]  cnt_r;
   logic [4:0]  cnt_s;

   logic        ready_r;
   logic        ce_r;
   logic        cdi_r;
   logic        valid_r;
   logic        busy_r;
   logic        done_r;

   // Next-state, shift-register, counter and current-word computation.
   always_comb begin
      state_s = state_r;
      shreg_s = shreg_r;
      cur_s   = cur_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_BOOT: begin
            state_s = ST_SHIFT;
            shreg_s = RESET_INIT;
            cur_s   = RESET_INIT;
            cnt_s   = 5'd0;
         end
         ST_SHIFT: begin
            shreg_s = {shreg_r[30:0], 1'b0};
            cnt_s   = cnt_r + 5'd1;
            // cnt_r counts bits already on CDI; bit 31 is the last one.
            if (cnt_r == 5'd31) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         ST_IDLE: begin
            if (req_valid) begin
               cur_s   = req_init;
               shreg_s = req_init;
               cnt_s   = 5'd0;
               // Reloading an identical word would only disturb a good LUT.
               if (SKIP_SAME && (req_init == cur_r)) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_SHIFT;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_BOOT;
         end
      endcase
   end

   // State, datapath and output registers.
   // Outputs are decoded from the next state, so each is registered yet
   // valid in the same cycle as the state it describes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_BOOT;
         shreg_r <= RESET_INIT;
         cur_r   <= RESET_INIT;
         cnt_r   <= 5'd0;
         ready_r <= 1'b0;
         ce_r    <= 1'b0;
         cdi_r   <= 1'b0;
         valid_r <= 1'b0;
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         shreg_r <= shreg_s;
         cur_r   <= cur_s;
         cnt_r   <= cnt_s;
         ready_r <= (state_s == ST_IDLE);
         ce_r    <= (state_s == ST_SHIFT);
         cdi_r   <= (state_s == ST_SHIFT) & shreg_s[31];
         // Only SHIFT and BOOT leave the LUT partially written.
         valid_r <= (state_s == ST_DONE) | (state_s == ST_IDLE);
         busy_r  <= (state_s != ST_IDLE);
         done_r  <= (state_s == ST_DONE);
      end
   end

   assign req_ready = ready_r;
   assign cfg_ce    = ce_r;
   assign cfg_cdi   = cdi_r;
   assign cfg_valid = valid_r;
   assign cur_init  = cur_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_cfglut_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cfglut_reconfig_ctrl
//
// Self-checking bench for cfglut_reconfig_ctrl.
// A transaction-level model turns every accepted word into a schedule of
// per-cycle expected outputs; a CFGLUT5 model is fed from the DUT's CE/CDI.
// All checks are counted in a single compare process.
// ---------------------------------------------------------------------------
module tb_cfglut_reconfig_ctrl;

   localparam logic [31:0] RINIT = 32'hEEEE_EEEE;

   logic        clock     = 1'b0;
   logic        reset     = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_init  = 32'h0;
   logic        req_ready;
   logic        cfg_ce;
   logic        cfg_cdi;
   logic        cfg_valid;
   logic [31:0] cur_init;
   logic        busy;
   logic        done;

   cfglut_reconfig_ctrl #(
      .RESET_INIT (RINIT),
      .SKIP_SAME  (1'b1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_init  (req_init),
      .req_ready (req_ready),
      .cfg_ce    (cfg_ce),
      .cfg_cdi   (cfg_cdi),
      .cfg_valid (cfg_valid),
      .cur_init  (cur_init),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        ready;
      logic        ce;
      logic        cdi;
      logic        valid;
      logic        busy;
      logic        done;
      logic [31:0] cur;
   } obs_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   obs_t        exp_o;
   obs_t        act_o;
   obs_t        sched_q[$];
   logic [31:0] m_cur      = RINIT;
   bit          m_in_reset = 1'b1;
   logic [31:0] lut        = 32'h0;

   string       lit_name[$];
   logic [31:0] lit_act[$];
   logic [31:0] lit_req[$];

   function automatic obs_t mk(input logic r, input logic ce, input logic cdi,
                               input logic v, input logic b, input logic d,
                               input logic [31:0] c);
      obs_t o;
      o.ready = r; o.ce = ce; o.cdi = cdi; o.valid = v;
      o.busy = b;  o.done = d; o.cur = c;
      return o;
   endfunction

   // 32 shift cycles (MSB first) followed by the done cycle
   function automatic void plan_load(input logic [31:0] w);
      for (int i = 0; i < 32; i++) sched_q.push_back(mk(1'b0, 1'b1, w[31-i], 1'b0, 1'b1, 1'b0, w));
      sched_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, w));
   endfunction

   function automatic logic lut_y(input logic [31:0] w, input logic a, input logic b);
      logic [4:0] addr;
      addr = {3'b000, b, a};
      return w[addr];
   endfunction

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
      lit_name.push_back(name);
      lit_act.push_back(act);
      lit_req.push_back(req);
   endtask

   initial exp_o = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RINIT);

   // Reference model: expected outputs for the cycle following each edge.
   initial forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
         sched_q.delete();
         m_cur      = RINIT;
         m_in_reset = 1'b1;
         exp_o      = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RINIT);
      end else begin
         if (m_in_reset) begin
            m_in_reset = 1'b0;
            plan_load(RINIT);
         end else if (exp_o.ready && req_valid) begin
            if (req_init == m_cur) sched_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, req_init));
            else plan_load(req_init);
            m_cur = req_init;
         end
         if (sched_q.size() > 0) exp_o = sched_q.pop_front();
         else exp_o = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_cur);
      end
   end

   // CFGLUT5 contents, driven only by the DUT's CE/CDI
   initial forever begin
      @(posedge clock);
      if (cfg_ce === 1'b1) lut = {lut[30:0], cfg_cdi};
   end

   // Single compare process: every cycle plus queued literal checks
   initial forever begin
      @(negedge clock);
      act_o = {req_ready, cfg_ce, cfg_cdi, cfg_valid, busy, done, cur_init};
      n_tests++;
      if (act_o !== exp_o) begin
         n_fail++;
         $display("FAIL outputs t=%0t got(rdy,ce,cdi,vld,busy,done,cur)=%b%b%b%b%b%b %h want=%b%b%b%b%b%b %h",
                  $time, act_o.ready, act_o.ce, act_o.cdi, act_o.valid, act_o.busy, act_o.done, act_o.cur,
                  exp_o.ready, exp_o.ce, exp_o.cdi, exp_o.valid, exp_o.busy, exp_o.done, exp_o.cur);
      end
      if (cfg_valid === 1'b1) begin
         n_tests++;
         if (lut !== cur_init) begin
            n_fail++;
            $display("FAIL lut_scoreboard t=%0t lut=%h cur_init=%h", $time, lut, cur_init);
         end
      end
      while (lit_name.size() > 0) begin
         string       nm;
         logic [31:0] a;
         logic [31:0] r;
         nm = lit_name.pop_front();
         a  = lit_act.pop_front();
         r  = lit_req.pop_front();
         n_tests++;
         if (a !== r) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, a, r);
         end
      end
   end

   // Count cycles until ready returns; optionally keep valid high with noise
   task automatic wait_ready(input bit noisy, output int low, output int ces);
      bit fin;
      low = 0; ces = 0; fin = 1'b0;
      while (!fin) begin
         @(negedge clock);
         if (req_ready === 1'b1) begin
            req_valid = 1'b0;
            fin = 1'b1;
         end else begin
            low++;
            if (cfg_ce === 1'b1) ces++;
            if (noisy) req_init = $urandom();
            if (low > 200) begin
               lit("timeout_wait_ready", 32'd1, 32'd0);
               fin = 1'b1;
            end
         end
      end
   endtask

   task automatic send(input logic [31:0] w, input bit noisy, output int low, output int ces);
      int n;
      n = 0;
      req_init  = w;
      req_valid = 1'b1;
      while (req_ready !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (n >= 100) lit("timeout_accept", 32'd1, 32'd0);
      @(posedge clock);
      #1;
      if (!noisy) req_valid = 1'b0;
      wait_ready(noisy, low, ces);
   endtask

   int          low;
   int          ces;
   int          gap;
   logic [31:0] w;
   logic [31:0] last_w;
   bit          nz;

   initial begin
      #2 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;

      // boot reload
      wait_ready(1'b0, low, ces);
      lit("t1_ce_cycles", ces, 32'd32);
      lit("t1_ready_low", low, 32'd34);
      lit("t1_lut", lut, 32'hEEEE_EEEE);
      lit("t1_y10", {31'd0, lut_y(lut, 1'b1, 1'b0)}, 32'd1);

      // AND function
      send(32'h8888_8888, 1'b0, low, ces);
      lit("t2_ce_cycles", ces, 32'd32);
      lit("t2_ready_low", low, 32'd33);
      lit("t2_lut", lut, 32'h8888_8888);
      lit("t2_y10", {31'd0, lut_y(lut, 1'b1, 1'b0)}, 32'd0);
      lit("t2_y11", {31'd0, lut_y(lut, 1'b1, 1'b1)}, 32'd1);

      // same word again: skip path
      send(32'h8888_8888, 1'b0, low, ces);
      lit("t3_ce_cycles", ces, 32'd0);
      lit("t3_ready_low", low, 32'd1);
      lit("t3_lut", lut, 32'h8888_8888);

      // XOR with req_valid held and req_init changing during the load
      send(32'h6666_6666, 1'b1, low, ces);
      lit("t4_ready_low", low, 32'd33);
      lit("t4_ce_cycles", ces, 32'd32);
      lit("t4_lut", lut, 32'h6666_6666);
      lit("t4_cur_init", cur_init, 32'h6666_6666);
      lit("t4_y11", {31'd0, lut_y(lut, 1'b1, 1'b1)}, 32'd0);

      // reset during shift cycle 10 of a load
      req_init  = 32'h1111_1111;
      req_valid = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      repeat (9) @(posedge clock);
      #1 reset = 1'b0;
      #1 lit("t5_reset_outputs", {27'd0, cfg_ce, busy, cfg_valid, req_ready, done}, 32'b01000);
      lit("t5_reset_cur", cur_init, 32'hEEEE_EEEE);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      wait_ready(1'b0, low, ces);
      lit("t5_ce_cycles", ces, 32'd32);
      lit("t5_ready_low", low, 32'd34);
      lit("t5_lut", lut, 32'hEEEE_EEEE);

      // random requests
      last_w = RINIT;
      for (int i = 0; i < 20; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            @(posedge clock);
            #1;
         end
         if ($urandom_range(0, 3) == 0) w = last_w;
         else w = $urandom();
         nz = ($urandom_range(0, 1) == 1);
         send(w, nz, low, ces);
         lit("t6_ce_cycles", ces, (w == last_w) ? 32'd0 : 32'd32);
         lit("t6_lut", lut, w);
         last_w = w;
      end

      @(negedge clock);
      @(negedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
